// File: rtl/operand_sequencer.sv
// Operand capture front-end for the ones'-complement subtractor: debounced load/clear buttons
// sequence operand A then B. Optional build macro: OPERAND_AUTO_RELOAD_EN.

module operand_sequencer_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pulse taken straight off the level edge so the FSM acts on the following clock.
  assign pulse = level & ~level_q;
endmodule

module operand_sequencer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             operands_valid,
  output logic [1:0]       state_led
);
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  state_t state;
  logic   load_p;
  logic   clear_p;

  operand_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_load),
    .pulse (load_p)
  );

  operand_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clear),
    .pulse (clear_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= LOAD_A;
      a              <= '0;
      b              <= '0;
      operands_valid <= 1'b0;
    end else if (clear_p) begin
      // Clear takes priority over a coincident load.
      state          <= LOAD_A;
      a              <= '0;
      b              <= '0;
      operands_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (load_p) begin
            a     <= sw;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_p) begin
            b              <= sw;
            operands_valid <= 1'b1;
            state          <= READY;
          end
        end
        READY: begin
          if (load_p) begin
`ifdef OPERAND_AUTO_RELOAD_EN
            a <= sw;
`else
            a              <= sw;
            operands_valid <= 1'b0;
            state          <= LOAD_B;
`endif
          end
        end
        default: begin
          state          <= LOAD_A;
          operands_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state_led = state;
endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer (DEBOUNCE_CYCLES=4); follows OPERAND_AUTO_RELOAD_EN if defined.

module tb_operand_sequencer;
  localparam int unsigned W = 4;
  localparam int unsigned DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         btn_load = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         operands_valid;
  logic [1:0]   state_led;

  operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clear      (btn_clear),
    .a              (a),
    .b              (b),
    .operands_valid (operands_valid),
    .state_led      (state_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ev;
    logic [1:0]   eled;
  } exp_t;

  exp_t sb[$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_v = 1'b0;
  logic [1:0]   m_st = 2'b00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_a = '0; m_b = '0; m_v = 1'b0; m_st = 2'b00;
  endtask

  task automatic m_load(input logic [W-1:0] v);
    case (m_st)
      2'b00: begin m_a = v; m_st = 2'b01; end
      2'b01: begin m_b = v; m_v = 1'b1; m_st = 2'b10; end
      default: begin
`ifdef OPERAND_AUTO_RELOAD_EN
        m_a = v;
`else
        m_a = v; m_v = 1'b0; m_st = 2'b01;
`endif
      end
    endcase
  endtask

  task automatic sb_push(input string tag);
    exp_t e;
    e.tag = tag; e.ea = m_a; e.eb = m_b; e.ev = m_v; e.eled = m_st;
    sb.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    check_val("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({e.tag, ".a"}, a, e.ea);
      check_val({e.tag, ".b"}, b, e.eb);
      check_val({e.tag, ".valid"}, operands_valid, e.ev);
      check_val({e.tag, ".led"}, state_led, e.eled);
    end
  endtask

  task automatic press(input logic ld, input logic cl, input int unsigned cycles);
    @(negedge clk);
    btn_load = ld;
    btn_clear = cl;
    repeat (cycles) @(negedge clk);
    btn_load = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic load_val(input logic [W-1:0] v, input string tag);
    @(negedge clk);
    sw = v;
    press(1'b1, 1'b0, 10);
    m_load(v);
    sb_push(tag);
    sw = ~v;  // outputs must not follow switches after capture
    @(negedge clk);
    sb_compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    sb_push("reset");
    @(negedge clk);
    sb_compare();

    // First load with latency measurement from the press edge
    @(negedge clk);
    sw = 4'h5;
    btn_load = 1'b1;
    n = 0;
    while (a === 4'h0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("load_latency", n, 2 + DB + 1);
    repeat (5) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    m_load(4'h5);
    sb_push("load_a5");
    sw = 4'hA;
    @(negedge clk);
    sb_compare();

    load_val(4'h3, "load_b3");

    // Bounce: high runs of 1, 2, 3 samples never reach the debounce threshold
    @(negedge clk);
    sw = 4'hF;
    btn_load = 1'b1; @(negedge clk);
    btn_load = 1'b0; @(negedge clk);
    btn_load = 1'b1; repeat (2) @(negedge clk);
    btn_load = 1'b0; @(negedge clk);
    btn_load = 1'b1; repeat (3) @(negedge clk);
    btn_load = 1'b0; repeat (12) @(negedge clk);
    sb_push("glitch");
    sb_compare();

    // Load and clear together: clear wins
    press(1'b1, 1'b1, 10);
    m_reset();
    sb_push("load_and_clear");
    sb_compare();

    load_val(4'h5, "reload_a5");
    load_val(4'h3, "reload_b3");
    load_val(4'h9, "ready_load9");

    // Back to LOAD_A, load A, then short reset in LOAD_B
    press(1'b0, 1'b1, 10);
    m_reset();
    sb_push("clear_only");
    sb_compare();
    load_val(4'h5, "pre_reset_a5");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    sb_push("mid_reset");
    @(negedge clk);
    sb_compare();

    load_val(4'h7, "post_reset_a7");
    load_val(4'h7, "post_reset_b7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
